// File: rtl/vga_pkg.sv
// VGA timing defaults, frame-buffer address width and colour palette.
// Shared by frame_scanout and the pixel writer.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int ADDR_W = 19;
  localparam int CNT_W  = 10;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
    logic fs;
  } pix_ctl_t;

  localparam pix_ctl_t CTL_IDLE = '{
    hs_n:    1'b1,
    vs_n:    1'b1,
    blank_n: 1'b0,
    fs:      1'b0
  };

  // Entry n is {r, g, b}; index 7 comes first in the literal.
  localparam logic [7:0][23:0] PALETTE = {
    24'hFFFFFF,
    24'h00FFFF,
    24'hFF00FF,
    24'h0000FF,
    24'hFFFF00,
    24'h00FF00,
    24'hFF0000,
    24'h000000
  };

  function automatic logic [23:0] pal_rgb(
    input logic [2:0] idx
  );
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters and sync/blank decode.
// Outputs describe the counter stage, before any pipeline delay.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic     clock,
  input  logic     resetn,
  input  logic     enable,
  output logic     visible,
  output logic     frame_end,
  output logic     in_vblank,
  output pix_ctl_t ctl
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_ON  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_OFF = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_ON  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_OFF = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic run_q, run_d;

  // run_q marks the first enabled clock as pixel (0,0).
  always_comb begin
    run_d  = enable;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!enable) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (run_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) vcnt_d = '0;
        else vcnt_d = vcnt_q + cnt_t'(1);
      end else begin
        hcnt_d = hcnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      run_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      run_q  <= run_d;
    end
  end

  logic hs_on, vs_on;

  always_comb begin
    hs_on = run_q && hcnt_q >= HS_ON && hcnt_q < HS_OFF;
    vs_on = run_q && vcnt_q >= VS_ON && vcnt_q < VS_OFF;
    visible = run_q && hcnt_q < H_VIS && vcnt_q < V_VIS;
    frame_end = run_q && hcnt_q == H_LAST
                && vcnt_q == V_LAST;
    in_vblank = vcnt_q >= V_VIS;
    ctl.hs_n    = !hs_on;
    ctl.vs_n    = !vs_on;
    ctl.blank_n = visible;
    ctl.fs      = run_q && hcnt_q == '0 && vcnt_q == '0;
  end

endmodule

// File: rtl/frame_scanout.sv
// Frame-buffer scan-out: address pipeline, sync alignment, colour.
// Define FRAME_SCANOUT_PALETTE_EN to map pixels through the palette.
module frame_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [2:0]        mem_rdata,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start,
  output logic              in_vblank
);

  logic     visible;
  logic     frame_end;
  pix_ctl_t ctl;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock     (clock),
    .resetn    (resetn),
    .enable    (enable),
    .visible   (visible),
    .frame_end (frame_end),
    .in_vblank (in_vblank),
    .ctl       (ctl)
  );

  addr_t    addr_q, addr_d;
  addr_t    raddr_q, raddr_d;
  pix_ctl_t s1_q, s1_d;
  pix_ctl_t s2_q, s2_d;

  // addr_q tracks v*H_ACTIVE+h of the counter stage by counting.
  always_comb begin
    addr_d  = addr_q;
    raddr_d = raddr_q;
    s1_d    = CTL_IDLE;
    s2_d    = CTL_IDLE;
    if (!enable) begin
      addr_d  = '0;
      raddr_d = '0;
    end else begin
      if (frame_end) addr_d = '0;
      else if (visible) addr_d = addr_q + addr_t'(1);
      if (visible) raddr_d = addr_q;
      s1_d = ctl;
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      raddr_q <= '0;
      s1_q    <= CTL_IDLE;
      s2_q    <= CTL_IDLE;
    end else begin
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  // mem_rdata already sits at the s2 stage; colour is a mapping only.
  logic [23:0] pix_rgb;

`ifdef FRAME_SCANOUT_PALETTE_EN
  assign pix_rgb = pal_rgb(mem_rdata);
`else
  assign pix_rgb = {{8{mem_rdata[0]}},
                    {8{mem_rdata[1]}},
                    {8{mem_rdata[2]}}};
`endif

  logic [23:0] out_rgb;

  assign out_rgb     = s2_q.blank_n ? pix_rgb : 24'h0;
  assign vga_r       = out_rgb[23:16];
  assign vga_g       = out_rgb[15:8];
  assign vga_b       = out_rgb[7:0];
  assign vga_hs      = s2_q.hs_n;
  assign vga_vs      = s2_q.vs_n;
  assign vga_blank_n = s2_q.blank_n;
  assign frame_start = s2_q.fs;
  assign mem_raddr   = raddr_q;

endmodule
